// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// mc_ctrl_pkg : opcodes, state encoding and control-field encodings for mc_ctrl
// Rev 1.0
// ============================================================================
package mc_ctrl_pkg;

    localparam logic [5:0] c_opR    = 6'b000000;
    localparam logic [5:0] c_opLw   = 6'b100011;
    localparam logic [5:0] c_opSw   = 6'b101011;
    localparam logic [5:0] c_opBeq  = 6'b000100;
    localparam logic [5:0] c_opJ    = 6'b000010;
    localparam logic [5:0] c_opAddi = 6'b001000;
    localparam logic [5:0] c_opBne  = 6'b000101;

    localparam logic [1:0] c_aluOpAdd   = 2'b00;
    localparam logic [1:0] c_aluOpSub   = 2'b01;
    localparam logic [1:0] c_aluOpFunct = 2'b10;

    localparam logic [1:0] c_srcBReg    = 2'b00;
    localparam logic [1:0] c_srcBFour   = 2'b01;
    localparam logic [1:0] c_srcBImm    = 2'b10;
    localparam logic [1:0] c_srcBImmSh2 = 2'b11;

    localparam logic [1:0] c_pcSrcAlu    = 2'b00;
    localparam logic [1:0] c_pcSrcAluOut = 2'b01;
    localparam logic [1:0] c_pcSrcJump   = 2'b10;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_EXEC   = 4'd2,
        ST_RWB    = 4'd3,
        ST_MEMADR = 4'd4,
        ST_MEMRD  = 4'd5,
        ST_MEMWB  = 4'd6,
        ST_MEMWR  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_JUMP   = 4'd9,
        ST_ADDIEX = 4'd10,
        ST_ADDIWB = 4'd11
    } state_t;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       branchNe;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memtoReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
        logic       instrDone;
        logic       illegalOp;
    } ctrl_t;

    function automatic logic opLegal(input logic [5:0] op);
        case (op)
            c_opR, c_opLw, c_opSw, c_opBeq, c_opJ: opLegal = 1'b1;
`ifdef MC_CTRL_EXT_OPS_EN
            c_opAddi, c_opBne:                     opLegal = 1'b1;
`endif
            default:                               opLegal = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_outdec.sv
`default_nettype none
// ============================================================================
// mc_ctrl_outdec : combinational state (+mem_ready, op) to control-word decode
// Rev 1.0
// ============================================================================
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t     i_state,
    input  logic       i_memReady,
    input  logic [5:0] i_op,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            ST_FETCH: begin
                o_ctrl.memRead  = 1'b1;
                o_ctrl.aluSrcB  = c_srcBFour;
                o_ctrl.aluOp    = c_aluOpAdd;
                o_ctrl.pcSource = c_pcSrcAlu;
                o_ctrl.irWrite  = i_memReady;
                o_ctrl.pcWrite  = i_memReady;
            end
            ST_DECODE: begin
                o_ctrl.aluSrcB   = c_srcBImmSh2;
                o_ctrl.aluOp     = c_aluOpAdd;
                o_ctrl.illegalOp = ~opLegal(i_op);
            end
            ST_EXEC: begin
                o_ctrl.aluSrcA = 1'b1;
                o_ctrl.aluSrcB = c_srcBReg;
                o_ctrl.aluOp   = c_aluOpFunct;
            end
            ST_RWB: begin
                o_ctrl.regDst    = 1'b1;
                o_ctrl.regWrite  = 1'b1;
                o_ctrl.instrDone = 1'b1;
            end
            ST_MEMADR: begin
                o_ctrl.aluSrcA = 1'b1;
                o_ctrl.aluSrcB = c_srcBImm;
                o_ctrl.aluOp   = c_aluOpAdd;
            end
            ST_MEMRD: begin
                o_ctrl.memRead = 1'b1;
                o_ctrl.iorD    = 1'b1;
            end
            ST_MEMWB: begin
                o_ctrl.memtoReg  = 1'b1;
                o_ctrl.regWrite  = 1'b1;
                o_ctrl.instrDone = 1'b1;
            end
            // The store completes on the ready cycle, so that is the retire cycle.
            ST_MEMWR: begin
                o_ctrl.memWrite  = 1'b1;
                o_ctrl.iorD      = 1'b1;
                o_ctrl.instrDone = i_memReady;
            end
            ST_BRANCH: begin
                o_ctrl.aluSrcA     = 1'b1;
                o_ctrl.aluSrcB     = c_srcBReg;
                o_ctrl.aluOp       = c_aluOpSub;
                o_ctrl.pcWriteCond = 1'b1;
                o_ctrl.pcSource    = c_pcSrcAluOut;
                o_ctrl.instrDone   = 1'b1;
`ifdef MC_CTRL_EXT_OPS_EN
                o_ctrl.branchNe    = (i_op == c_opBne);
`endif
            end
            ST_JUMP: begin
                o_ctrl.pcWrite   = 1'b1;
                o_ctrl.pcSource  = c_pcSrcJump;
                o_ctrl.instrDone = 1'b1;
            end
`ifdef MC_CTRL_EXT_OPS_EN
            ST_ADDIEX: begin
                o_ctrl.aluSrcA = 1'b1;
                o_ctrl.aluSrcB = c_srcBImm;
                o_ctrl.aluOp   = c_aluOpAdd;
            end
            ST_ADDIWB: begin
                o_ctrl.regWrite  = 1'b1;
                o_ctrl.instrDone = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// mc_ctrl : multi-cycle MIPS controller with memory wait states and retire count
// Optional ADDI/BNE support via MC_CTRL_EXT_OPS_EN.  Rev 1.0
// ============================================================================
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    op,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               BranchNe,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         PCSource,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [CNT_W-1:0]   retired
);

    state_t           r_state;
    state_t           w_nextState;
    ctrl_t            w_ctrl;
    logic [5:0]       w_op;
    logic [CNT_W-1:0] r_retired;

    assign w_op = 6'(op);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_FETCH:  if (mem_ready) w_nextState = ST_DECODE;
            ST_DECODE: begin
                case (w_op)
                    c_opR:          w_nextState = ST_EXEC;
                    c_opLw, c_opSw: w_nextState = ST_MEMADR;
                    c_opBeq:        w_nextState = ST_BRANCH;
                    c_opJ:          w_nextState = ST_JUMP;
`ifdef MC_CTRL_EXT_OPS_EN
                    c_opBne:        w_nextState = ST_BRANCH;
                    c_opAddi:       w_nextState = ST_ADDIEX;
`endif
                    default:        w_nextState = ST_FETCH;
                endcase
            end
            ST_EXEC:   w_nextState = ST_RWB;
            // IR holds op stable, so it still tells load from store here.
            ST_MEMADR: w_nextState = (w_op == c_opSw) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:  if (mem_ready) w_nextState = ST_MEMWB;
            ST_MEMWR:  if (mem_ready) w_nextState = ST_FETCH;
`ifdef MC_CTRL_EXT_OPS_EN
            ST_ADDIEX: w_nextState = ST_ADDIWB;
`endif
            default:   w_nextState = ST_FETCH;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .i_state    (r_state),
        .i_memReady (mem_ready),
        .i_op       (w_op),
        .o_ctrl     (w_ctrl)
    );

    // Strobes are masked during reset so an abandoned instruction cannot write.
    assign PCWrite     = w_ctrl.pcWrite     & rst_n;
    assign PCWriteCond = w_ctrl.pcWriteCond & rst_n;
    assign IRWrite     = w_ctrl.irWrite     & rst_n;
    assign RegWrite    = w_ctrl.regWrite    & rst_n;
    assign MemRead     = w_ctrl.memRead     & rst_n;
    assign MemWrite    = w_ctrl.memWrite    & rst_n;
    assign instr_done  = w_ctrl.instrDone   & rst_n;
    assign illegal_op  = w_ctrl.illegalOp   & rst_n;
    assign BranchNe    = w_ctrl.branchNe;
    assign IorD        = w_ctrl.iorD;
    assign MemtoReg    = w_ctrl.memtoReg;
    assign RegDst      = w_ctrl.regDst;
    assign ALUSrcA     = w_ctrl.aluSrcA;
    assign ALUSrcB     = w_ctrl.aluSrcB;
    assign ALUOp       = ALUOP_W'(w_ctrl.aluOp);
    assign PCSource    = w_ctrl.pcSource;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if (instr_done) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mc_ctrl : scoreboard bench for mc_ctrl, per-cycle control-word checks
// Rev 1.0
// ============================================================================
module tb_mc_ctrl;

    localparam int TB_CNT_W = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [5:0]          op;
    logic                mem_ready;
    logic                PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite;
    logic                IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]          ALUSrcB, ALUOp, PCSource;
    logic                instr_done, illegal_op;
    logic [TB_CNT_W-1:0] retired;

    always #5 clk = ~clk;

    mc_ctrl #(.OP_W(6), .ALUOP_W(2), .CNT_W(TB_CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .BranchNe   (BranchNe),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .MemtoReg   (MemtoReg),
        .RegDst     (RegDst),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .PCSource   (PCSource),
        .instr_done (instr_done),
        .illegal_op (illegal_op),
        .retired    (retired)
    );

    logic [18:0] w_obs;
    logic [7:0]  w_en;
    assign w_obs = {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
                    MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                    instr_done, illegal_op};
    assign w_en  = {PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite,
                    instr_done, illegal_op};

    typedef struct {
        bit          mr;
        logic [18:0] exp;
        string       tag;
    } step_t;

    step_t               stimQ[$];
    int                  nCompared = 0;
    int                  nMismatch = 0;
    logic [TB_CNT_W-1:0] expRetired;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatch++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] mk(input bit pcw, input bit pcwc, input bit bne,
                                       input bit iord, input bit mrd, input bit mwr,
                                       input bit irw, input bit m2r, input bit rdst,
                                       input bit rw, input bit asa, input logic [1:0] asb,
                                       input logic [1:0] aop, input logic [1:0] pcs,
                                       input bit done, input bit ill);
        return {pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, done, ill};
    endfunction

    function automatic logic [18:0] fetchW(input bit mr);
        return mk(mr, 0, 0, 0, 1, 0, mr, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0);
    endfunction
    function automatic logic [18:0] decW(input bit ill);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, ill);
    endfunction
    function automatic logic [18:0] memRdW(input bit mr);
        return mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    endfunction
    function automatic logic [18:0] memWrW(input bit mr);
        return mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, mr, 0);
    endfunction
    function automatic logic [18:0] branchW(input bit bne);
        return mk(0, 1, bne, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 1, 0);
    endfunction

    function automatic bit tbLegal(input logic [5:0] o);
        case (o)
            6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010: return 1'b1;
`ifdef MC_CTRL_EXT_OPS_EN
            6'b001000, 6'b000101: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    task automatic push(input bit mr, input logic [18:0] e, input string tag);
        step_t s;
        s.mr  = mr;
        s.exp = e;
        s.tag = tag;
        stimQ.push_back(s);
    endtask

    task automatic drain();
        step_t s;
        while (stimQ.size() > 0) begin
            s = stimQ.pop_front();
            mem_ready = s.mr;
            #2;
            checkVal(s.tag, 32'(w_obs), 32'(s.exp));
            @(negedge clk);
        end
    endtask

    task automatic runInstr(input logic [5:0] opc, input int fetchWaits, input int memWaits,
                            input string name);
        bit legal;
        legal = tbLegal(opc);
        op = opc;
        for (int i = 0; i < fetchWaits; i++) push(1'b0, fetchW(1'b0), {name, "/fetchWait"});
        push(1'b1, fetchW(1'b1), {name, "/fetch"});
        push(1'b1, decW(!legal), {name, "/decode"});
        if (legal) begin
            case (opc)
                6'b000000: begin
                    push(1'b1, mk(0,0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0), {name, "/exec"});
                    push(1'b1, mk(0,0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,1,0), {name, "/rwb"});
                end
                6'b100011: begin
                    push(1'b1, mk(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0), {name, "/memadr"});
                    for (int i = 0; i < memWaits; i++) push(1'b0, memRdW(1'b0), {name, "/memrdWait"});
                    push(1'b1, memRdW(1'b1), {name, "/memrd"});
                    push(1'b1, mk(0,0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1,0), {name, "/memwb"});
                end
                6'b101011: begin
                    push(1'b1, mk(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0), {name, "/memadr"});
                    for (int i = 0; i < memWaits; i++) push(1'b0, memWrW(1'b0), {name, "/memwrWait"});
                    push(1'b1, memWrW(1'b1), {name, "/memwr"});
                end
                6'b000100: push(1'b1, branchW(1'b0), {name, "/branch"});
                6'b000010: push(1'b1, mk(1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0), {name, "/jump"});
`ifdef MC_CTRL_EXT_OPS_EN
                6'b001000: begin
                    push(1'b1, mk(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0), {name, "/addiex"});
                    push(1'b1, mk(0,0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,1,0), {name, "/addiwb"});
                end
                6'b000101: push(1'b1, branchW(1'b1), {name, "/bne"});
`endif
                default: ;
            endcase
        end
        drain();
        if (legal) expRetired = expRetired + 1'b1;
        checkVal({name, "/retired"}, 32'(retired), 32'(expRetired));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        mem_ready  = 1'b1;
        op         = 6'b111111;
        expRetired = '0;

        @(negedge clk);
        #2 checkVal("reset/enables0", 32'(w_en), 32'h0);
        @(negedge clk);
        #2 checkVal("reset/enables1", 32'(w_en), 32'h0);
        checkVal("reset/retired", 32'(retired), 32'h0);
        rst_n = 1'b1;

        runInstr(6'b000000, 0, 0, "rtype");
        runInstr(6'b100011, 0, 2, "lwWait2");
        runInstr(6'b000000, 2, 0, "rtypeFetchWait");
        runInstr(6'b101011, 0, 0, "sw");
        runInstr(6'b000100, 0, 0, "beq");
        runInstr(6'b000010, 0, 0, "j");
        runInstr(6'b111111, 0, 0, "illegal3f");
        runInstr(6'b001000, 0, 0, "addi");
        runInstr(6'b000101, 0, 0, "bne");
        runInstr(6'b101011, 0, 1, "swWait1");
        runInstr(6'b100011, 1, 0, "lwFetchWait");

        while (expRetired != {TB_CNT_W{1'b1}}) runInstr(6'b000010, 0, 0, "jFill");
        runInstr(6'b000010, 0, 0, "jWrap");
        checkVal("wrap/zero", 32'(retired), 32'h0);

        op = 6'b101011;
        push(1'b1, fetchW(1'b1), "rstMemwr/fetch");
        push(1'b1, decW(1'b0), "rstMemwr/decode");
        push(1'b1, mk(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0), "rstMemwr/memadr");
        push(1'b0, memWrW(1'b0), "rstMemwr/memwrWait");
        drain();
        mem_ready = 1'b0;
        rst_n     = 1'b0;
        #2 checkVal("rstMemwr/enables", 32'(w_en), 32'h0);
        @(negedge clk);
        rst_n      = 1'b1;
        expRetired = '0;
        checkVal("rstMemwr/retired", 32'(retired), 32'h0);
        runInstr(6'b000000, 0, 0, "rtypeAfterReset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
`default_nettype wire
